bus_drive_arbiter: RTL and testbench

Sequences the active-low output enables of a bank of 74LS244-style tristate drivers that share one bus segment. It grants at most one requester at a time using round-robin, and enforces a hold limit. Every handoff includes a break-before-make turnaround so no two drivers ever drive together. It sits between the bus-cycle logic of each master (CPU, DMA, refresh, boot PROM) and the `G` enable pins of their buffer banks.

---
 rtl/bus_arb_pkg.sv | 38 +++
 rtl/rr_pick.sv | 22 ++
 rtl/bus_drive_arbiter.sv | 130 +++++++++++++
 tb/tb_bus_drive_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared definitions for the bus-drive arbiter family: FSM states, default
// parameters and the round-robin search used by rr_pick.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_TURN  = 2'd2
    } arb_state_e;

    localparam int MAX_NREQ        = 8;
    localparam int DEF_NREQ        = 4;
    localparam int DEF_TURN_CYCLES = 1;
    localparam int DEF_MAX_HOLD    = 16;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } rr_result_t;

    // Search vec from ptr+1 upwards and wrap. Callers zero the bits above their
    // own width, which makes this 8-wide wrap behave as a modulo-NREQ wrap.
    function automatic rr_result_t rr_next(input logic [2:0] ptr,
                                           input logic [MAX_NREQ-1:0] vec);
        rr_result_t res;
        logic [2:0] cand;
        res = '0;
        for (int i = 1; i <= MAX_NREQ; i++) begin
            cand = ptr + 3'(i);
            if (!res.valid && vec[cand]) begin
                res.valid = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of vec after position ptr.
module rr_pick
    import bus_arb_pkg::*;
#(
    parameter  int N  = DEF_NREQ,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  vec,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          valid
);

    rr_result_t w_res;

    always_comb begin
        w_res = rr_next(3'(ptr), MAX_NREQ'(vec));
        idx   = IW'(w_res.idx);
        valid = w_res.valid;
    end

endmodule

// File: rtl/bus_drive_arbiter.sv
// Round-robin sequencer for the active-low enables of tristate driver banks
// sharing one bus, with a hold limit and a break-before-make turnaround.
module bus_drive_arbiter
    import bus_arb_pkg::*;
#(
    parameter  int NREQ        = DEF_NREQ,
    parameter  int TURN_CYCLES = DEF_TURN_CYCLES,
    parameter  int MAX_HOLD    = DEF_MAX_HOLD,
    localparam int OW          = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [NREQ-1:0] oe_n,
    output logic            busy,
    output logic [OW-1:0]   owner,
    output logic            preempt,
    output arb_state_e      dbg_state
);

    // Handshake: req[i] is a level held for as long as bank i wants the bus.
    // gnt[i] rises one cycle after req[i] is sampled in IDLE and stays up until
    // req[i] is sampled low or the hold limit expires; every output is a flop.
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    localparam logic [3:0] TURN_LOAD = 4'(TURN_CYCLES - 1);
    localparam bit         HOLD_EN   = (MAX_HOLD != 0);

    arb_state_e      r_state;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_oe_n;
    logic            r_busy;
    logic [OW-1:0]   r_owner;
    logic            r_preempt;
    logic [7:0]      r_hold;
    logic [3:0]      r_turn;

    arb_state_e      w_state_nx;
    logic [NREQ-1:0] w_gnt_nx;
    logic [OW-1:0]   w_owner_nx;
    logic            w_preempt_nx;
    logic [7:0]      w_hold_nx;
    logic [3:0]      w_turn_nx;
    logic [OW-1:0]   w_pick_idx;
    logic            w_pick_valid;

    rr_pick #(.N(NREQ)) u_rr_pick (
        .vec   (req),
        .ptr   (r_owner),
        .idx   (w_pick_idx),
        .valid (w_pick_valid)
    );

    always_comb begin
        w_state_nx   = r_state;
        w_gnt_nx     = r_gnt;
        w_owner_nx   = r_owner;
        w_preempt_nx = 1'b0;
        w_hold_nx    = r_hold;
        w_turn_nx    = r_turn;
        unique case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nx = ST_DRIVE;
                    w_owner_nx = w_pick_idx;
                    w_gnt_nx   = NREQ'(1) << w_pick_idx;
                    w_hold_nx  = '0;
                end
            end
            ST_DRIVE: begin
                // A voluntary drop wins over expiry, so preempt stays low then.
                if (!req[r_owner]) begin
                    w_state_nx = ST_TURN;
                    w_gnt_nx   = '0;
                    w_turn_nx  = TURN_LOAD;
                    w_hold_nx  = '0;
                end else if (HOLD_EN && (r_hold == HOLD_LAST)) begin
                    w_state_nx   = ST_TURN;
                    w_gnt_nx     = '0;
                    w_turn_nx    = TURN_LOAD;
                    w_hold_nx    = '0;
                    w_preempt_nx = 1'b1;
                end else begin
                    w_hold_nx = r_hold + 8'd1;
                end
            end
            ST_TURN: begin
                if (r_turn == '0) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_turn_nx = r_turn - 4'd1;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_gnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_oe_n    <= '1;
            r_busy    <= 1'b0;
            r_owner   <= OW'(NREQ - 1);
            r_preempt <= 1'b0;
            r_hold    <= '0;
            r_turn    <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_gnt     <= w_gnt_nx;
            r_oe_n    <= ~w_gnt_nx;
            r_busy    <= (w_state_nx != ST_IDLE);
            r_owner   <= w_owner_nx;
            r_preempt <= w_preempt_nx;
            r_hold    <= w_hold_nx;
            r_turn    <= w_turn_nx;
        end
    end

    assign gnt       = r_gnt;
    assign oe_n      = r_oe_n;
    assign busy      = r_busy;
    assign owner     = r_owner;
    assign preempt   = r_preempt;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_bus_drive_arbiter.sv
// Bench for bus_drive_arbiter: three parameterisations, each compared every
// cycle against a timestamp-based model, plus directed literal scenarios.
module tb_bus_drive_arbiter;
    import bus_arb_pkg::*;

    localparam int NI = 3;
    localparam int N  = 4;

    logic         clk     = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] req_v   [NI];
    logic [N-1:0] gnt_v   [NI];
    logic [N-1:0] oe_v    [NI];
    logic         busy_v  [NI];
    logic [1:0]   owner_v [NI];
    logic         pre_v   [NI];
    arb_state_e   dbg_v   [NI];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Instance 0: turn 1, hold 4. Instance 1: turn 3, hold 16. Instance 2: turn 1, unlimited.
    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int T  = (g == 1) ? 3 : 1;
        localparam int MH = (g == 0) ? 4 : ((g == 1) ? 16 : 0);

        bus_drive_arbiter #(.NREQ(N), .TURN_CYCLES(T), .MAX_HOLD(MH)) u_dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .req       (req_v[g]),
            .gnt       (gnt_v[g]),
            .oe_n      (oe_v[g]),
            .busy      (busy_v[g]),
            .owner     (owner_v[g]),
            .preempt   (pre_v[g]),
            .dbg_state (dbg_v[g])
        );

        // Model: edge counter, current grant with the number of cycles already
        // driven, and the first edge at which a new grant is allowed.
        int cyc;
        bit m_granted;
        int m_owner;
        int m_hold;
        int m_free_at;
        bit m_pre;

        always @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cyc       = 0;
                m_granted = 1'b0;
                m_owner   = N - 1;
                m_hold    = 0;
                m_free_at = 0;
                m_pre     = 1'b0;
            end else begin
                cyc   = cyc + 1;
                m_pre = 1'b0;
                if (m_granted) begin
                    if (!req_v[g][m_owner]) begin
                        m_granted = 1'b0;
                        m_free_at = cyc + T + 1;
                    end else if (MH != 0 && m_hold == MH) begin
                        m_granted = 1'b0;
                        m_pre     = 1'b1;
                        m_free_at = cyc + T + 1;
                    end else begin
                        m_hold = m_hold + 1;
                    end
                end else if (cyc >= m_free_at && req_v[g] != '0) begin
                    for (int k = 1; k <= N; k++) begin
                        if (!m_granted && req_v[g][(m_owner + k) % N]) begin
                            m_owner   = (m_owner + k) % N;
                            m_granted = 1'b1;
                            m_hold    = 1;
                        end
                    end
                end
            end
        end

        logic [N-1:0] e_gnt;
        arb_state_e   e_state;

        always @(negedge clk) begin
            if (reset_n) begin
                e_gnt   = m_granted ? (4'(1) << m_owner) : '0;
                e_state = m_granted ? ST_DRIVE : ((cyc + 1 < m_free_at) ? ST_TURN : ST_IDLE);
                check($sformatf("inst%0d outputs{gnt,oe_n,busy,owner,preempt,state}", g),
                      32'({gnt_v[g], oe_v[g], busy_v[g], owner_v[g], pre_v[g], dbg_v[g]}),
                      32'({e_gnt, ~e_gnt, (e_state != ST_IDLE), 2'(m_owner), m_pre, e_state}));
                check($sformatf("inst%0d gnt_onehot0_drive_only", g),
                      32'($onehot0(gnt_v[g]) && (gnt_v[g] == '0 || dbg_v[g] == ST_DRIVE)),
                      32'd1);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        for (int i = 0; i < NI; i++) req_v[i] = '0;
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
    endtask

    task automatic wait_grant(input int inst);
        int budget = 100;
        while (gnt_v[inst] == '0 && budget > 0) begin
            budget--;
            @(negedge clk);
        end
        check("wait_grant_budget", 32'(budget > 0), 32'd1);
    endtask

    // Measures one grant: all-high samples before it, its owner and length,
    // and preempt in the first sample after it ends.
    task automatic next_grant(input int inst, output int who, output int len,
                              output int gap, output logic pre_seen);
        int budget;
        logic [N-1:0] g0;
        budget = 400;
        gap = 0;
        len = 0;
        while (gnt_v[inst] == '0 && budget > 0) begin
            gap++;
            budget--;
            @(negedge clk);
        end
        who = int'(owner_v[inst]);
        g0  = gnt_v[inst];
        while (g0 != '0 && gnt_v[inst] == g0 && budget > 0) begin
            len++;
            budget--;
            @(negedge clk);
        end
        pre_seen = pre_v[inst];
        check("grant_budget", 32'(budget > 0), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   who, len, gap, held, pre_cnt;
        logic pre;
        int   exp_order [5] = '{0, 1, 2, 3, 0};

        for (int i = 0; i < NI; i++) req_v[i] = '0;

        // Reset values.
        do_reset();
        check("reset_oe_n",    32'(oe_v[0]),    32'hF);
        check("reset_gnt",     32'(gnt_v[0]),   32'h0);
        check("reset_busy",    32'(busy_v[0]),  32'd0);
        check("reset_owner",   32'(owner_v[0]), 32'd3);
        check("reset_preempt", 32'(pre_v[0]),   32'd0);

        // Single request, then release: one TURN cycle, then IDLE.
        req_v[0] = 4'b0001;
        @(negedge clk);
        check("single_oe_n",  32'(oe_v[0]),    32'hE);
        check("single_owner", 32'(owner_v[0]), 32'd0);
        req_v[0] = 4'b0000;
        @(negedge clk);
        check("release_oe_n", 32'(oe_v[0]),   32'hF);
        check("release_busy", 32'(busy_v[0]), 32'd1);
        @(negedge clk);
        check("idle_busy",    32'(busy_v[0]), 32'd0);
        check("idle_oe_n",    32'(oe_v[0]),   32'hF);

        // All four requesting with hold limit 4; the all-high gap is the TURN
        // cycle plus the IDLE arbitration cycle.
        do_reset();
        req_v[0] = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            next_grant(0, who, len, gap, pre);
            check($sformatf("rr_order[%0d]", k), 32'(who), 32'(exp_order[k]));
            check($sformatf("hold_len[%0d]", k), 32'(len), 32'd4);
            check($sformatf("hold_preempt[%0d]", k), 32'(pre), 32'd1);
            if (k > 0) check($sformatf("hold_gap[%0d]", k), 32'(gap), 32'd2);
        end

        // Preempted bit 0 still requesting, but bit 2 comes first.
        req_v[0] = 4'b0101;
        wait_grant(0);
        check("rr_after_preempt_owner", 32'(owner_v[0]), 32'd2);

        // Asynchronous reset in the middle of bit 2's grant.
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_oe_n",    32'(oe_v[0]),    32'hF);
        check("async_reset_gnt",     32'(gnt_v[0]),   32'h0);
        check("async_reset_busy",    32'(busy_v[0]),  32'd0);
        check("async_reset_owner",   32'(owner_v[0]), 32'd3);
        check("async_reset_preempt", 32'(pre_v[0]),   32'd0);
        req_v[0] = 4'b0110;
        @(negedge clk);
        #2 reset_n = 1'b1;
        wait_grant(0);
        check("post_reset_lowest", 32'(owner_v[0]), 32'd1);

        // Turnaround of 3: two requesters alternate with 4 all-high samples.
        do_reset();
        req_v[1] = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            next_grant(1, who, len, gap, pre);
            check($sformatf("t3_order[%0d]", k), 32'(who), 32'(k % 2));
            check($sformatf("t3_len[%0d]", k), 32'(len), 32'd16);
            check($sformatf("t3_preempt[%0d]", k), 32'(pre), 32'd1);
            if (k > 0) check($sformatf("t3_gap[%0d]", k), 32'(gap), 32'd4);
        end

        // Unlimited hold: one continuous grant for 100 cycles.
        req_v[1] = '0;
        req_v[2] = 4'b0010;
        held    = 0;
        pre_cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (gnt_v[2] == 4'b0010) held++;
            if (pre_v[2]) pre_cnt++;
        end
        check("unlimited_held_cycles", 32'(held), 32'd100);
        check("unlimited_preempts",    32'(pre_cnt), 32'd0);
        req_v[2] = '0;
        @(negedge clk);
        check("unlimited_release_oe_n",    32'(oe_v[2]), 32'hF);
        check("unlimited_release_preempt", 32'(pre_v[2]), 32'd0);

        // Random request levels on all instances with one reset mid-run.
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if ($urandom_range(0, 3) == 0) req_v[i] = 4'($urandom_range(0, 15));
            end
            if (c == 5000) do_reset();
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
